dkong_scandbl: RTL and testbench
================================

Name: dkong_scandbl

Overview:
- Video output stage directly downstream of the colour palette.
- Takes the 4-bit-per-gun RGB stream at the 6 MHz pixel rate (15.6 kHz lines) and line-doubles it into a 31 kHz stream with a 12 MHz pixel rate.
- Uses a ping-pong pair of line buffers.
- Regenerates HS, VS and DE for the VGA/DisplayPort output path.

Parameters:
- H_TOTAL, 384: pixel clocks per input line; also the output line length in 12 MHz enables.
- ACTIVE, 256: stored pixels per line, which is the buffer depth.
- RD_START, 64: output count at which DE rises.
- HS_START, 16: output count at which O_HS falls.
- HS_WIDTH, 46: output HS low width in 12 MHz enables.

Ports:
- CLK_24M  in  1  system clock.
- W_1EF_RST  in  1  asynchronous active-low reset.
- CLK_6M_EN  in  1  input pixel enable, one CLK_24M cycle in four.
- I_R  in  4  palette red.
- I_G  in  4  palette green.
- I_B  in  4  palette blue.
- I_HBLANKn  in  1  input active-pixel qualifier, high while active.
- I_HSYNCn  in  1  input horizontal sync, active-low.
- I_VSYNCn  in  1  input vertical sync, active-low.
- O_R  out  4  doubled red.
- O_G  out  4  doubled green.
- O_B  out  4  doubled blue.
- O_HS  out  1  output horizontal sync, active-low.
- O_VS  out  1  output vertical sync, active-low.
- O_DE  out  1  output data enable.

Behaviour:
- Reset: already decided — reset W_1EF_RST, asynchronous, active-low; clock CLK_24M.
  - While reset is low: O_R/O_G/O_B=0, O_HS=1, O_VS=1, O_DE=0, wr_x=0, rd_x=0, bank=0, en12 toggle=0, all edge-detect registers=1.
  - Reset may assert mid-line. Recovery needs no input sync; the first input HS fall realigns everything.
- 12 MHz enable: an internal toggle flips every CLK_24M. en12 is high when toggle=1, which gives 2 enables per CLK_6M_EN period.
- Edge detect: I_HSYNCn and I_HBLANKn are sampled on CLK_6M_EN. hs_fall is a 1-to-0 transition; hb_rise is a 0-to-1 transition.
- Write side (CLK_6M_EN only):
  - hb_rise sets wr_x=0.
  - While I_HBLANKn=1 and wr_x<ACTIVE, write {I_R,I_G,I_B} to buffer[bank][wr_x], then wr_x+1.
  - When wr_x reaches ACTIVE, further pixels are discarded and wr_x saturates.
  - hs_fall toggles bank.
- Read side (en12 only):
  - rd_x increments and wraps from H_TOTAL-1 to 0.
  - On hs_fall, rd_x is forced to 0 on the next en12 and line_ph is cleared. Each wrap sets line_ph=1.
  - Each input line therefore produces two output lines (line_ph 0 and 1), both reading buffer[~bank].
  - With no input HS, rd_x free-runs.
- Buffer: 2×ACTIVE×12-bit inferred dual-port RAM with synchronous read (1 CLK_24M latency).
  - Read address = rd_x-RD_START, valid when RD_START <= rd_x < RD_START+ACTIVE.
  - Read and write banks always differ; there is no collision.
- Output pipeline (updated on en12; DE/HS/VS delayed to match the RAM latency so all outputs are aligned):
  - O_DE=1 iff the read address is valid.
  - O_R/G/B = RAM data when O_DE=1, else 0.
  - O_HS=0 iff HS_START <= rd_x < HS_START+HS_WIDTH.
  - Latency from rd_x value to outputs: exactly one en12 period.
- VS: I_VSYNCn is captured at each output line start (rd_x=0), so O_VS changes only on output line boundaries. Each input VS line yields two output VS lines.
- Simultaneous hs_fall and hb_rise in the same CLK_6M_EN: both actions apply (bank toggle, wr_x=0).

Optional Feature:
- Macro: SCANLINES_EN.
- Defined: on line_ph=1 output lines, each gun is halved ({1'b0,x[3:1]}). DE and sync timing are unchanged.
- Undefined: both output lines of a pair are identical.

Test Plan:
- Reset mid-line: assert W_1EF_RST low for 10 cycles during an active line -> O_R/G/B=0, O_HS=1, O_VS=1, O_DE=0 immediately; normal output resumes two input lines after the next HS fall.
- Ramp line: input pixels with R=G=B=x[3:0] for x=0..255, HS period 384 CLK_6M_EN -> on the next input line, two output lines each carry exactly 256 DE-high enables at rd_x 64..319, RGB sequence 0,1,..,15,0,.. repeating.
- Sync timing: steady input -> O_HS low for 46 en12 starting at rd_x=16 on every output line; O_HS period = 768 CLK_24M.
- Overlong active: I_HBLANKn high for 300 pixels -> only the first 256 pixels are stored; pixels 256..299 never appear; O_DE width stays 256.
- VS doubling: I_VSYNCn low for 3 input lines -> O_VS low for exactly 6 output lines, edges coincident with rd_x=0.
- SCANLINES_EN defined, constant input RGB=F,8,2 -> line_ph 0 outputs F,8,2; line_ph 1 outputs 7,4,1.

Source files
------------

// File: rtl/dkong_scandbl.sv
// dkong_scandbl: 15.6 kHz -> 31 kHz line doubler using a ping-pong pair of line buffers.
// Optional macro SCANLINES_EN halves every gun on the second output line of each pair.
module dkong_scandbl #(
  parameter int H_TOTAL  = 384,
  parameter int ACTIVE   = 256,
  parameter int RD_START = 64,
  parameter int HS_START = 16,
  parameter int HS_WIDTH = 46
) (
  input  logic       CLK_24M,
  input  logic       W_1EF_RST,
  input  logic       CLK_6M_EN,
  input  logic [3:0] I_R,
  input  logic [3:0] I_G,
  input  logic [3:0] I_B,
  input  logic       I_HBLANKn,
  input  logic       I_HSYNCn,
  input  logic       I_VSYNCn,
  output logic [3:0] O_R,
  output logic [3:0] O_G,
  output logic [3:0] O_B,
  output logic       O_HS,
  output logic       O_VS,
  output logic       O_DE
);
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int AW = $clog2(ACTIVE);
  localparam logic [XW-1:0] L_HLAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] L_ACT   = XW'(ACTIVE);
  localparam logic [XW-1:0] L_RDS   = XW'(RD_START);
  localparam logic [XW-1:0] L_RDE   = XW'(RD_START + ACTIVE);
  localparam logic [XW-1:0] L_HSS   = XW'(HS_START);
  localparam logic [XW-1:0] L_HSE   = XW'(HS_START + HS_WIDTH);

  typedef struct packed { logic [3:0] r, g, b; } pix_t;

  logic          r_tog;
  logic          r_hs_d, r_hb_d;
  logic [XW-1:0] r_wr_x, r_rd_x;
  logic          r_bank, r_pend;
  pix_t          r_rdata;
  pix_t          r_mem [2*ACTIVE];

  logic          w_en12, w_hs_fall, w_hb_rise, w_we, w_rd_ok, w_hs_on;
  logic [XW-1:0] w_wa;
  logic [AW-1:0] w_ra;
  pix_t          w_pix;

  assign w_en12    = r_tog;
  assign w_hs_fall = CLK_6M_EN & r_hs_d & ~I_HSYNCn;
  assign w_hb_rise = CLK_6M_EN & ~r_hb_d & I_HBLANKn;
  // the first active pixel lands at address 0 in the same enable that sees the blank rise
  assign w_wa      = w_hb_rise ? '0 : r_wr_x;
  assign w_we      = CLK_6M_EN & I_HBLANKn & (w_wa < L_ACT);
  assign w_ra      = AW'(r_rd_x - L_RDS);
  assign w_rd_ok   = (r_rd_x >= L_RDS) && (r_rd_x < L_RDE);
  assign w_hs_on   = (r_rd_x >= L_HSS) && (r_rd_x < L_HSE);

  // write bank and read bank are always complementary, so the two ports never collide
  always_ff @(posedge CLK_24M) begin
    if (w_we) r_mem[{r_bank, w_wa[AW-1:0]}] <= {I_R, I_G, I_B};
    r_rdata <= r_mem[{~r_bank, w_ra}];
  end

  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      r_tog  <= 1'b0;
      r_hs_d <= 1'b1;
      r_hb_d <= 1'b1;
      r_wr_x <= '0;
      r_bank <= 1'b0;
    end else begin
      r_tog <= ~r_tog;
      if (CLK_6M_EN) begin
        r_hs_d <= I_HSYNCn;
        r_hb_d <= I_HBLANKn;
        if (w_we)      r_wr_x <= w_wa + XW'(1);
        if (w_hs_fall) r_bank <= ~r_bank;
      end
    end
  end

  // hs_fall is held pending so the restart lands on an en12 strictly after it
  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      r_rd_x <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_en12) begin
        if (r_pend || r_rd_x == L_HLAST) r_rd_x <= '0;
        else                             r_rd_x <= r_rd_x + XW'(1);
        r_pend <= 1'b0;
      end
      if (w_hs_fall) r_pend <= 1'b1;
    end
  end

`ifdef SCANLINES_EN
  logic r_line_ph;

  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST)                  r_line_ph <= 1'b0;
    else if (w_en12) begin
      if (r_pend)                    r_line_ph <= 1'b0;
      else if (r_rd_x == L_HLAST)    r_line_ph <= 1'b1;
    end
  end

  always_comb begin
    w_pix = r_rdata;
    if (r_line_ph) w_pix = {1'b0, r_rdata.r[3:1], 1'b0, r_rdata.g[3:1], 1'b0, r_rdata.b[3:1]};
  end
`else
  assign w_pix = r_rdata;
`endif

  // RAM data arrives one CLK_24M after the address, i.e. just before the next en12,
  // so all outputs reflect the rd_x value of one en12 period earlier
  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      {O_R, O_G, O_B} <= '0;
      O_HS <= 1'b1;
      O_VS <= 1'b1;
      O_DE <= 1'b0;
    end else if (w_en12) begin
      O_DE <= w_rd_ok;
      {O_R, O_G, O_B} <= w_rd_ok ? w_pix : '0;
      O_HS <= ~w_hs_on;
      if (r_rd_x == '0) O_VS <= I_VSYNCn;
    end
  end
endmodule

// File: tb/tb_dkong_scandbl.sv
// tb_dkong_scandbl: random and directed input lines, output trace compared with a line-level model.
`timescale 1ns/1ps
module tb_dkong_scandbl;
  localparam int HT = 384, ACT = 256, RDS = 64, HSS = 16, HSW = 46;
  localparam int HB0 = 64, HSL = 32;
  localparam int MAXC = 65536, MAXL = 32, MAXP = 320;
  localparam logic [14:0] RSTV = {12'h000, 3'b110};
`ifdef SCANLINES_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, en6 = 1'b0;
  logic [3:0] ir = '0, ig = '0, ib = '0;
  logic hbn = 1'b0, hsn = 1'b1, vsn = 1'b1;
  logic [3:0] o_r, o_g, o_b;
  logic o_hs, o_vs, o_de;

  dkong_scandbl dut (
    .CLK_24M(clk), .W_1EF_RST(rst_n), .CLK_6M_EN(en6),
    .I_R(ir), .I_G(ig), .I_B(ib),
    .I_HBLANKn(hbn), .I_HSYNCn(hsn), .I_VSYNCn(vsn),
    .O_R(o_r), .O_G(o_g), .O_B(o_b),
    .O_HS(o_hs), .O_VS(o_vs), .O_DE(o_de)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [11:0] tr_rgb [MAXC];
  logic        tr_hs  [MAXC];
  logic        tr_vs  [MAXC];
  logic        tr_de  [MAXC];
  logic [11:0] lpix   [MAXL][MAXP];
  int          nact   [MAXL];
  logic        lvs    [MAXL];
  int          ch     [MAXL];

  function automatic logic [11:0] shade(input logic [11:0] p, input int ph);
    if (SCAN && ph == 1) return {1'b0, p[11:9], 1'b0, p[7:5], 1'b0, p[3:1]};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (cyc < MAXC) begin
      tr_rgb[cyc] = {o_r, o_g, o_b};
      tr_hs[cyc]  = o_hs;
      tr_vs[cyc]  = o_vs;
      tr_de[cyc]  = o_de;
    end
  endtask

  // mode 0 random, 1 ramp, 2 constant F82
  task automatic mk_line(input int l, input int mode, input int n, input logic vs);
    logic [3:0] v;
    nact[l] = n;
    lvs[l]  = vs;
    for (int x = 0; x < MAXP; x++) begin
      v = 4'(x);
      case (mode)
        1:       lpix[l][x] = {v, v, v};
        2:       lpix[l][x] = 12'hF82;
        default: lpix[l][x] = 12'($urandom);
      endcase
    end
  endtask

  // one input pixel = four CLK_24M cycles, CLK_6M_EN on the first
  task automatic drive_pix(input int l, input int h);
    int a;
    a   = h - HB0;
    hsn = (h >= HSL);
    hbn = (a >= 0 && a < nact[l]);
    vsn = lvs[l];
    if (hbn) {ir, ig, ib} = lpix[l][a];
    else     {ir, ig, ib} = 12'($urandom);
    for (int c = 0; c < 4; c++) begin
      en6 = (c == 0);
      if (c == 0 && h == 0) ch[l] = cyc + 1;
      tick();
    end
    en6 = 1'b0;
  endtask

  task automatic drive_line(input int l, input int h0, input int h1);
    for (int h = h0; h < h1; h++) drive_pix(l, h);
  endtask

  // two output lines after the HS fall of input line l carry input line l-1
  task automatic check_pair(input int l, input string nm);
    int brgb = 0, bhs = 0, bde = 0, bvs = 0, nde = 0, fk = -1, fph = 0;
    logic [11:0] fgot = '0, fexp = '0, xrgb;
    logic xde, xhs;
    for (int i = 0; i < 4*HT; i++) begin
      int e, k, ph;
      e  = ch[l] + 3 + i;
      k  = (i / 2) % HT;
      ph = i / (2*HT);
      xde = (k >= RDS && k < RDS + ACT);
      xhs = !(k >= HSS && k < HSS + HSW);
      xrgb = 12'h000;
      if (xde) xrgb = shade(lpix[l-1][k-RDS], ph);
      if (tr_rgb[e] !== xrgb) begin
        if (brgb == 0) begin fk = k; fph = ph; fgot = tr_rgb[e]; fexp = xrgb; end
        brgb++;
      end
      if (tr_hs[e] !== xhs)    bhs++;
      if (tr_de[e] !== xde)    bde++;
      if (tr_vs[e] !== lvs[l]) bvs++;
      if (tr_de[e] === 1'b1)   nde++;
    end
    checks++;
    if (brgb != 0) begin
      errors++;
      $display("FAIL %s rgb: %0d bad cycles, first rd_x=%0d ph=%0d got %h want %h", nm, brgb, fk, fph, fgot, fexp);
    end
    checks++;
    if (bhs != 0) begin errors++; $display("FAIL %s hs: %0d bad cycles, want 0", nm, bhs); end
    checks++;
    if (bde != 0) begin errors++; $display("FAIL %s de: %0d bad cycles, want 0", nm, bde); end
    checks++;
    if (bvs != 0) begin errors++; $display("FAIL %s vs: %0d bad cycles, want 0", nm, bvs); end
    checks++;
    if (nde != 4*ACT) begin errors++; $display("FAIL %s de_width: got %0d want %0d", nm, nde, 4*ACT); end
  endtask

  task automatic test_reset_init();
    int bad = 0;
    logic [14:0] last;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      last = {o_r, o_g, o_b, o_hs, o_vs, o_de};
      if (last !== RSTV) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_init: got %h want %h", last, RSTV); end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_ramp();
    mk_line(0, 1, 256, 1'b1);
    mk_line(1, 0, 256, 1'b1);
    mk_line(2, 0, 256, 1'b1);
    for (int l = 0; l < 3; l++) drive_line(l, 0, HT);
    check_pair(1, "ramp");
  endtask

  task automatic test_random();
    mk_line(3, 0, 256, 1'b1);
    mk_line(4, 0, 256, 1'b1);
    drive_line(3, 0, HT);
    drive_line(4, 0, HT);
    check_pair(2, "rand_a");
    check_pair(3, "rand_b");
  endtask

  task automatic test_sync();
    int nf = 0, bsp = 0, bw = 0, first = -1, prev = -1;
    for (int e = ch[1] + 3; e < ch[4] + 3; e++) begin
      if (tr_hs[e-1] === 1'b1 && tr_hs[e] === 1'b0) begin
        int w;
        w = 0;
        while (w < 400 && tr_hs[e+w] === 1'b0) w++;
        if (w != 2*HSW) bw++;
        if (prev >= 0 && e - prev != 2*HT) bsp++;
        if (first < 0) first = e;
        prev = e;
        nf++;
      end
    end
    checks++;
    if (nf != 6) begin errors++; $display("FAIL sync_count: got %0d want 6", nf); end
    checks++;
    if (bw != 0) begin errors++; $display("FAIL sync_width: %0d bad widths, want 0", bw); end
    checks++;
    if (bsp != 0) begin errors++; $display("FAIL sync_period: %0d bad periods, want 0", bsp); end
    checks++;
    if (first != ch[1] + 3 + 2*HSS) begin
      errors++;
      $display("FAIL sync_first: got %0d want %0d", first - ch[1], 3 + 2*HSS);
    end
  endtask

  task automatic test_overlong();
    mk_line(5, 0, 300, 1'b1);
    mk_line(6, 0, 256, 1'b1);
    mk_line(7, 0, 256, 1'b1);
    for (int l = 5; l < 8; l++) drive_line(l, 0, HT);
    check_pair(5, "pre_overlong");
    check_pair(6, "overlong");
  endtask

  task automatic test_vs();
    int nlow = 0;
    for (int l = 8; l < 16; l++) mk_line(l, 0, 256, !(l >= 10 && l <= 12));
    for (int l = 8; l < 16; l++) drive_line(l, 0, HT);
    for (int l = 8; l < 15; l++) check_pair(l, "vs_pair");
    for (int e = ch[8] + 3; e < ch[15] + 3; e++) if (tr_vs[e] === 1'b0) nlow++;
    checks++;
    if (nlow != 6*2*HT) begin errors++; $display("FAIL vs_low: got %0d cycles want %0d", nlow, 6*2*HT); end
    checks++;
    if (tr_vs[ch[10]+2] !== 1'b1 || tr_vs[ch[10]+3] !== 1'b0 ||
        tr_vs[ch[13]+2] !== 1'b0 || tr_vs[ch[13]+3] !== 1'b1) begin
      errors++;
      $display("FAIL vs_edges: got %b%b%b%b want 1001",
               tr_vs[ch[10]+2], tr_vs[ch[10]+3], tr_vs[ch[13]+2], tr_vs[ch[13]+3]);
    end
  endtask

  task automatic test_scanlines();
    mk_line(16, 2, 256, 1'b1);
    mk_line(17, 0, 256, 1'b1);
    mk_line(18, 0, 256, 1'b1);
    for (int l = 16; l < 19; l++) drive_line(l, 0, HT);
    check_pair(17, "scanlines");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [14:0] v;
    mk_line(19, 0, 256, 1'b1);
    drive_line(19, 0, 150);
    rst_n = 1'b0;
    #1;
    v = {o_r, o_g, o_b, o_hs, o_vs, o_de};
    checks++;
    if (v !== RSTV) begin errors++; $display("FAIL reset_async: got %h want %h", v, RSTV); end
    for (int i = 0; i < 10; i++) begin
      tick();
      v = {o_r, o_g, o_b, o_hs, o_vs, o_de};
      if (v !== RSTV) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_hold: %0d bad cycles, last %h want %h", bad, v, RSTV); end
    rst_n = 1'b1;
    cyc   = 0;
    drive_line(19, 150, HT);
    for (int l = 20; l < 23; l++) mk_line(l, 0, 256, 1'b1);
    for (int l = 20; l < 23; l++) drive_line(l, 0, HT);
    check_pair(21, "post_reset");
  endtask

  initial begin
    test_reset_init();
    test_ramp();
    test_random();
    test_sync();
    test_overlong();
    test_vs();
    test_scanlines();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
